// File: rtl/psu_redund_ctrl_if.sv
// PSU status/enable bundle between the redundancy controller and the PSU block.
// The controller (master) consumes PSU status and drives the per-PSU enables.
interface psu_redund_ctrl_if #(
  parameter int NUM_PSU = 2
);
  logic [NUM_PSU-1:0] ps_prsnt_n;
  logic [NUM_PSU-1:0] ps_acok;
  logic [NUM_PSU-1:0] ps_fail;
  logic               brownout_warning;
  logic [NUM_PSU-1:0] ps_enable;

  modport master (
    input  ps_prsnt_n,
    input  ps_acok,
    input  ps_fail,
    input  brownout_warning,
    output ps_enable
  );

  modport slave (
    output ps_prsnt_n,
    output ps_acok,
    output ps_fail,
    output brownout_warning,
    input  ps_enable
  );
endinterface

// File: rtl/psu_redund_ctrl.sv
// PSU redundancy controller: staggered power-up, all-on mode, and cold
// redundancy with periodic make-before-break primary rotation and failover.
module psu_redund_ctrl #(
  parameter int NUM_PSU    = 2,
  parameter int STAGGER_MS = 10,
  parameter int ROTATE_S   = 3600
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       t1ms,
  input  logic                       t1s,
  input  logic                       power_supply_on,
  input  logic                       cr_enable,
  psu_redund_ctrl_if.master          psu,
  output logic [$clog2(NUM_PSU)-1:0] active_idx,
  output logic [2:0]                 cr_state,
  output logic                       cr_failover
);

  localparam int IDX_W = $clog2(NUM_PSU);
  localparam int MS_W  = $clog2(STAGGER_MS) + 1;
  localparam int S_W   = $clog2(ROTATE_S) + 1;
  localparam logic [MS_W-1:0] MS_LIM = MS_W'(STAGGER_MS);
  localparam logic [S_W-1:0]  S_LIM  = S_W'(ROTATE_S);
  localparam logic [MS_W-1:0] MS_MAX = '1;
  localparam logic [S_W-1:0]  S_MAX  = '1;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_STAGGER   = 3'd1,
    ST_ALL_ON    = 3'd2,
    ST_CR_ACTIVE = 3'd3,
    ST_ROTATE    = 3'd4,
    ST_FAILOVER  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_PSU-1:0] ps_enable_q, ps_enable_d;
  logic [IDX_W-1:0]   active_idx_q, active_idx_d;
  logic [IDX_W-1:0]   next_idx_q, next_idx_d;
  logic [IDX_W-1:0]   stg_idx_q, stg_idx_d;
  logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic [S_W-1:0]     s_cnt_q, s_cnt_d;
  logic               cr_failover_q, cr_failover_d;

  logic [NUM_PSU-1:0] present;
  logic [NUM_PSU-1:0] healthy;
  logic [3:0]         n_healthy;
  logic               has_present;
  logic               has_higher;
  logic               rot_found;
  logic [IDX_W-1:0]   lowest_present;
  logic [IDX_W-1:0]   lowest_healthy;
  logic [IDX_W-1:0]   higher_idx;
  logic [IDX_W-1:0]   rot_idx;
  logic [MS_W-1:0]    ms_inc;
  logic [S_W-1:0]     s_inc;
  logic               fail_now;
  logic               cr_ok;

  function automatic logic [NUM_PSU-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NUM_PSU'(1) << idx;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PSU; gi++) begin : g_health
      assign present[gi] = ~psu.ps_prsnt_n[gi];
      assign healthy[gi] = ~psu.ps_prsnt_n[gi] & psu.ps_acok[gi] & ~psu.ps_fail[gi];
    end
  endgenerate

  // Slot searches: lowest present/healthy, next present above the stagger
  // cursor, next healthy slot after the primary (wrapping), healthy count.
  always_comb begin
    n_healthy      = '0;
    has_present    = 1'b0;
    has_higher     = 1'b0;
    rot_found      = 1'b0;
    lowest_present = '0;
    lowest_healthy = '0;
    higher_idx     = '0;
    rot_idx        = active_idx_q;
    for (int i = NUM_PSU - 1; i >= 0; i--) begin
      if (present[i]) begin
        has_present    = 1'b1;
        lowest_present = IDX_W'(i);
      end
      if (healthy[i]) begin
        lowest_healthy = IDX_W'(i);
      end
      if (present[i] && (i > int'(stg_idx_q))) begin
        has_higher = 1'b1;
        higher_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_PSU; i++) begin
      if (healthy[i]) begin
        n_healthy = n_healthy + 4'd1;
      end
    end
    for (int k = 1; k < NUM_PSU; k++) begin
      if (!rot_found && healthy[(int'(active_idx_q) + k) % NUM_PSU]) begin
        rot_found = 1'b1;
        rot_idx   = IDX_W'((int'(active_idx_q) + k) % NUM_PSU);
      end
    end
  end

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d       = state_q;
    ps_enable_d   = ps_enable_q;
    active_idx_d  = active_idx_q;
    next_idx_d    = next_idx_q;
    stg_idx_d     = stg_idx_q;
    ms_cnt_d      = ms_cnt_q;
    s_cnt_d       = s_cnt_q;
    cr_failover_d = 1'b0;

    // Saturating increments; the tick strobes are independent of each other.
    ms_inc   = (t1ms && (ms_cnt_q != MS_MAX)) ? ms_cnt_q + 1'b1 : ms_cnt_q;
    s_inc    = (t1s && (s_cnt_q != S_MAX)) ? s_cnt_q + 1'b1 : s_cnt_q;
    fail_now = !healthy[active_idx_q] || psu.brownout_warning ||
               ((state_q == ST_ROTATE) && !healthy[next_idx_q]);
    cr_ok    = cr_enable && (n_healthy >= 4'd2);

    if (!power_supply_on) begin
      state_d     = ST_OFF;
      ps_enable_d = '1;
      ms_cnt_d    = '0;
      s_cnt_d     = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          ms_cnt_d = '0;
          s_cnt_d  = '0;
          if (has_present) begin
            state_d     = ST_STAGGER;
            ps_enable_d = onehot(lowest_present);
            stg_idx_d   = lowest_present;
          end else begin
            state_d     = ST_ALL_ON;
            ps_enable_d = '0;
          end
        end
        ST_STAGGER: begin
          if (!has_higher) begin
            if (cr_ok) begin
              state_d      = ST_CR_ACTIVE;
              active_idx_d = lowest_healthy;
              ps_enable_d  = onehot(lowest_healthy);
              s_cnt_d      = '0;
              ms_cnt_d     = '0;
            end else begin
              state_d     = ST_ALL_ON;
              ps_enable_d = present;
            end
          end else if (ms_inc >= MS_LIM) begin
            ps_enable_d = ps_enable_q | onehot(higher_idx);
            stg_idx_d   = higher_idx;
            ms_cnt_d    = '0;
          end else begin
            ms_cnt_d = ms_inc;
          end
        end
        ST_ALL_ON: begin
          ps_enable_d = present;
          if (cr_ok) begin
            state_d      = ST_CR_ACTIVE;
            active_idx_d = lowest_healthy;
            ps_enable_d  = onehot(lowest_healthy);
            s_cnt_d      = '0;
            ms_cnt_d     = '0;
          end
        end
        ST_CR_ACTIVE: begin
          if (fail_now) begin
            state_d       = ST_FAILOVER;
            ps_enable_d   = present;
            cr_failover_d = 1'b1;
          end else if (!cr_ok) begin
            state_d     = ST_ALL_ON;
            ps_enable_d = present;
            s_cnt_d     = '0;
          end else if (s_inc >= S_LIM) begin
            s_cnt_d = '0;
            if (rot_idx != active_idx_q) begin
              state_d     = ST_ROTATE;
              next_idx_d  = rot_idx;
              ps_enable_d = onehot(active_idx_q) | onehot(rot_idx);
              ms_cnt_d    = '0;
            end else begin
              ps_enable_d = onehot(active_idx_q);
            end
          end else begin
            s_cnt_d     = s_inc;
            ps_enable_d = onehot(active_idx_q);
          end
        end
        ST_ROTATE: begin
          if (fail_now) begin
            state_d       = ST_FAILOVER;
            ps_enable_d   = present;
            cr_failover_d = 1'b1;
          end else if (!cr_ok) begin
            state_d     = ST_ALL_ON;
            ps_enable_d = present;
            ms_cnt_d    = '0;
          end else if (ms_inc >= MS_LIM) begin
            // Overlap done: hand over to the new primary, old one drops.
            state_d      = ST_CR_ACTIVE;
            active_idx_d = next_idx_q;
            ps_enable_d  = onehot(next_idx_q);
            ms_cnt_d     = '0;
            s_cnt_d      = '0;
          end else begin
            ms_cnt_d    = ms_inc;
            ps_enable_d = onehot(active_idx_q) | onehot(next_idx_q);
          end
        end
        ST_FAILOVER: begin
          ps_enable_d = present;
        end
        default: begin
          state_d     = ST_OFF;
          ps_enable_d = '1;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_OFF;
      ps_enable_q   <= '1;
      active_idx_q  <= '0;
      next_idx_q    <= '0;
      stg_idx_q     <= '0;
      ms_cnt_q      <= '0;
      s_cnt_q       <= '0;
      cr_failover_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ps_enable_q   <= ps_enable_d;
      active_idx_q  <= active_idx_d;
      next_idx_q    <= next_idx_d;
      stg_idx_q     <= stg_idx_d;
      ms_cnt_q      <= ms_cnt_d;
      s_cnt_q       <= s_cnt_d;
      cr_failover_q <= cr_failover_d;
    end
  end

  assign psu.ps_enable = ps_enable_q;
  assign active_idx    = active_idx_q;
  assign cr_state      = state_q;
  assign cr_failover   = cr_failover_q;

endmodule

// File: tb/tb_psu_redund_ctrl.sv
// Directed bench: a 2-slot controller (fast rotation) and a 3-slot controller.
module tb_psu_redund_ctrl;

  logic clk;
  logic reset;
  logic t1ms;
  logic t1s;
  logic pwr_a, cr_a;
  logic pwr_b, cr_b;

  logic [0:0] a_idx;
  logic [2:0] a_state;
  logic       a_fo;
  logic [1:0] b_idx;
  logic [2:0] b_state;
  logic       b_fo;

  int total;
  int bad;

  psu_redund_ctrl_if #(.NUM_PSU(2)) bus_a ();
  psu_redund_ctrl_if #(.NUM_PSU(3)) bus_b ();

  psu_redund_ctrl #(.NUM_PSU(2), .STAGGER_MS(10), .ROTATE_S(3)) dut_a (
    .clk             (clk),
    .reset           (reset),
    .t1ms            (t1ms),
    .t1s             (t1s),
    .power_supply_on (pwr_a),
    .cr_enable       (cr_a),
    .psu             (bus_a),
    .active_idx      (a_idx),
    .cr_state        (a_state),
    .cr_failover     (a_fo)
  );

  psu_redund_ctrl #(.NUM_PSU(3), .STAGGER_MS(10), .ROTATE_S(3)) dut_b (
    .clk             (clk),
    .reset           (reset),
    .t1ms            (t1ms),
    .t1s             (t1s),
    .power_supply_on (pwr_b),
    .cr_enable       (cr_b),
    .psu             (bus_b),
    .active_idx      (b_idx),
    .cr_state        (b_state),
    .cr_failover     (b_fo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ms(input int n);
    for (int i = 0; i < n; i++) begin
      t1ms = 1'b1;
      tick();
      t1ms = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_s(input int n);
    for (int i = 0; i < n; i++) begin
      t1s = 1'b1;
      tick();
      t1s = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (a_state !== 3'd0) begin bad++; $display("FAIL reset_state_a: got %0d want 0", a_state); end
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL reset_en_a: got %b want 11", bus_a.ps_enable); end
    total++; if (a_idx !== 1'b0) begin bad++; $display("FAIL reset_idx_a: got %0d want 0", a_idx); end
    total++; if (a_fo !== 1'b0) begin bad++; $display("FAIL reset_fo_a: got %b want 0", a_fo); end
    total++; if (bus_b.ps_enable !== 3'b111) begin bad++; $display("FAIL reset_en_b: got %b want 111", bus_b.ps_enable); end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_stagger_all_on();
    bus_a.ps_prsnt_n = 2'b00;
    bus_a.ps_acok    = 2'b11;
    bus_a.ps_fail    = 2'b00;
    cr_a  = 1'b0;
    pwr_a = 1'b1;
    tick();
    total++; if (a_state !== 3'd1) begin bad++; $display("FAIL stg_state0: got %0d want 1", a_state); end
    total++; if (bus_a.ps_enable !== 2'b01) begin bad++; $display("FAIL stg_en0: got %b want 01", bus_a.ps_enable); end
    pulse_ms(9);
    total++; if (bus_a.ps_enable !== 2'b01) begin bad++; $display("FAIL stg_en9: got %b want 01", bus_a.ps_enable); end
    t1ms = 1'b1;
    tick();
    t1ms = 1'b0;
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL stg_en10: got %b want 11", bus_a.ps_enable); end
    total++; if (a_state !== 3'd1) begin bad++; $display("FAIL stg_state10: got %0d want 1", a_state); end
    tick();
    total++; if (a_state !== 3'd2) begin bad++; $display("FAIL allon_state: got %0d want 2", a_state); end
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL allon_en: got %b want 11", bus_a.ps_enable); end
    $display("test_stagger_all_on done");
  endtask

  task automatic test_cr_rotate();
    cr_a = 1'b1;
    tick();
    total++; if (a_state !== 3'd3) begin bad++; $display("FAIL cr_state: got %0d want 3", a_state); end
    total++; if (a_idx !== 1'b0) begin bad++; $display("FAIL cr_idx: got %0d want 0", a_idx); end
    total++; if (bus_a.ps_enable !== 2'b01) begin bad++; $display("FAIL cr_en: got %b want 01", bus_a.ps_enable); end
    pulse_s(2);
    total++; if (a_state !== 3'd3) begin bad++; $display("FAIL cr_hold_state: got %0d want 3", a_state); end
    t1s = 1'b1;
    tick();
    t1s = 1'b0;
    total++; if (a_state !== 3'd4) begin bad++; $display("FAIL rot_state: got %0d want 4", a_state); end
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL rot_en: got %b want 11", bus_a.ps_enable); end
    pulse_ms(9);
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL rot_en9: got %b want 11", bus_a.ps_enable); end
    total++; if (a_idx !== 1'b0) begin bad++; $display("FAIL rot_idx9: got %0d want 0", a_idx); end
    t1ms = 1'b1;
    tick();
    t1ms = 1'b0;
    total++; if (a_state !== 3'd3) begin bad++; $display("FAIL rot_done_state: got %0d want 3", a_state); end
    total++; if (a_idx !== 1'b1) begin bad++; $display("FAIL rot_done_idx: got %0d want 1", a_idx); end
    total++; if (bus_a.ps_enable !== 2'b10) begin bad++; $display("FAIL rot_done_en: got %b want 10", bus_a.ps_enable); end
    $display("test_cr_rotate done");
  endtask

  task automatic test_failover();
    // Rotate back to slot 0 first (wrap from the top slot).
    pulse_s(3);
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL wrap_rot_en: got %b want 11", bus_a.ps_enable); end
    pulse_ms(10);
    total++; if (a_idx !== 1'b0) begin bad++; $display("FAIL wrap_idx: got %0d want 0", a_idx); end
    total++; if (bus_a.ps_enable !== 2'b01) begin bad++; $display("FAIL wrap_en: got %b want 01", bus_a.ps_enable); end
    bus_a.ps_fail = 2'b01;
    tick();
    total++; if (a_state !== 3'd5) begin bad++; $display("FAIL fo_state: got %0d want 5", a_state); end
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL fo_en: got %b want 11", bus_a.ps_enable); end
    total++; if (a_fo !== 1'b1) begin bad++; $display("FAIL fo_pulse: got %b want 1", a_fo); end
    tick();
    total++; if (a_fo !== 1'b0) begin bad++; $display("FAIL fo_pulse_once: got %b want 0", a_fo); end
    cr_a = 1'b0;
    tick();
    tick();
    total++; if (a_state !== 3'd5) begin bad++; $display("FAIL fo_cr0_state: got %0d want 5", a_state); end
    cr_a = 1'b1;
    tick();
    tick();
    total++; if (a_state !== 3'd5) begin bad++; $display("FAIL fo_cr1_state: got %0d want 5", a_state); end
    total++; if (a_fo !== 1'b0) begin bad++; $display("FAIL fo_cr1_pulse: got %b want 0", a_fo); end
    bus_a.ps_fail = 2'b00;
    pwr_a = 1'b0;
    tick();
    total++; if (a_state !== 3'd0) begin bad++; $display("FAIL off_state: got %0d want 0", a_state); end
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL off_en: got %b want 11", bus_a.ps_enable); end
    $display("test_failover done");
  endtask

  task automatic test_brownout_vs_rotate();
    pwr_a = 1'b1;
    tick();
    pulse_ms(10);
    total++; if (a_state !== 3'd3) begin bad++; $display("FAIL bo_cr_state: got %0d want 3", a_state); end
    total++; if (bus_a.ps_enable !== 2'b01) begin bad++; $display("FAIL bo_cr_en: got %b want 01", bus_a.ps_enable); end
    pulse_s(2);
    t1s = 1'b1;
    bus_a.brownout_warning = 1'b1;
    tick();
    t1s = 1'b0;
    bus_a.brownout_warning = 1'b0;
    total++; if (a_state !== 3'd5) begin bad++; $display("FAIL bo_state: got %0d want 5", a_state); end
    total++; if (a_fo !== 1'b1) begin bad++; $display("FAIL bo_pulse: got %b want 1", a_fo); end
    tick();
    total++; if (a_state !== 3'd5) begin bad++; $display("FAIL bo_no_rotate: got %0d want 5", a_state); end
    pwr_a = 1'b0;
    tick();
    $display("test_brownout_vs_rotate done");
  endtask

  task automatic test_reset_mid_rotate();
    pwr_a = 1'b1;
    tick();
    pulse_ms(10);
    pulse_s(3);
    pulse_ms(10);
    total++; if (a_idx !== 1'b1) begin bad++; $display("FAIL mr_idx: got %0d want 1", a_idx); end
    pulse_s(3);
    pulse_ms(3);
    total++; if (a_state !== 3'd4) begin bad++; $display("FAIL mr_rot_state: got %0d want 4", a_state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (a_state !== 3'd0) begin bad++; $display("FAIL mr_state: got %0d want 0", a_state); end
    total++; if (bus_a.ps_enable !== 2'b11) begin bad++; $display("FAIL mr_en: got %b want 11", bus_a.ps_enable); end
    total++; if (a_idx !== 1'b0) begin bad++; $display("FAIL mr_idx0: got %0d want 0", a_idx); end
    tick();
    total++; if (bus_a.ps_enable !== 2'b01) begin bad++; $display("FAIL mr_restart_en: got %b want 01", bus_a.ps_enable); end
    pwr_a = 1'b0;
    tick();
    $display("test_reset_mid_rotate done");
  endtask

  task automatic test_skip_absent();
    bus_b.ps_prsnt_n = 3'b001;
    bus_b.ps_acok    = 3'b110;
    bus_b.ps_fail    = 3'b000;
    cr_b  = 1'b1;
    pwr_b = 1'b1;
    tick();
    total++; if (bus_b.ps_enable !== 3'b010) begin bad++; $display("FAIL skip_en0: got %b want 010", bus_b.ps_enable); end
    pulse_ms(9);
    total++; if (bus_b.ps_enable !== 3'b010) begin bad++; $display("FAIL skip_en9: got %b want 010", bus_b.ps_enable); end
    t1ms = 1'b1;
    tick();
    t1ms = 1'b0;
    total++; if (bus_b.ps_enable !== 3'b110) begin bad++; $display("FAIL skip_en10: got %b want 110", bus_b.ps_enable); end
    tick();
    total++; if (b_state !== 3'd3) begin bad++; $display("FAIL skip_cr_state: got %0d want 3", b_state); end
    total++; if (b_idx !== 2'd1) begin bad++; $display("FAIL skip_idx: got %0d want 1", b_idx); end
    total++; if (bus_b.ps_enable !== 3'b010) begin bad++; $display("FAIL skip_cr_en: got %b want 010", bus_b.ps_enable); end
    $display("test_skip_absent done");
  endtask

  task automatic test_degrade();
    bus_b.ps_acok = 3'b010;
    tick();
    total++; if (b_state !== 3'd2) begin bad++; $display("FAIL deg_state: got %0d want 2", b_state); end
    total++; if (bus_b.ps_enable !== 3'b110) begin bad++; $display("FAIL deg_en: got %b want 110", bus_b.ps_enable); end
    total++; if (b_fo !== 1'b0) begin bad++; $display("FAIL deg_fo: got %b want 0", b_fo); end
    $display("test_degrade done");
  endtask

  task automatic test_no_present();
    pwr_b = 1'b0;
    tick();
    total++; if (bus_b.ps_enable !== 3'b111) begin bad++; $display("FAIL np_off_en: got %b want 111", bus_b.ps_enable); end
    bus_b.ps_prsnt_n = 3'b111;
    pwr_b = 1'b1;
    tick();
    total++; if (b_state !== 3'd2) begin bad++; $display("FAIL np_state: got %0d want 2", b_state); end
    total++; if (bus_b.ps_enable !== 3'b000) begin bad++; $display("FAIL np_en: got %b want 000", bus_b.ps_enable); end
    $display("test_no_present done");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    t1ms  = 1'b0;
    t1s   = 1'b0;
    pwr_a = 1'b0;
    cr_a  = 1'b0;
    pwr_b = 1'b0;
    cr_b  = 1'b0;
    bus_a.ps_prsnt_n       = 2'b00;
    bus_a.ps_acok          = 2'b11;
    bus_a.ps_fail          = 2'b00;
    bus_a.brownout_warning = 1'b0;
    bus_b.ps_prsnt_n       = 3'b000;
    bus_b.ps_acok          = 3'b111;
    bus_b.ps_fail          = 3'b000;
    bus_b.brownout_warning = 1'b0;

    test_reset();
    test_stagger_all_on();
    test_cr_rotate();
    test_failover();
    test_brownout_vs_rotate();
    test_reset_mid_rotate();
    test_skip_absent();
    test_degrade();
    test_no_present();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psu_redund_ctrl.md
PSU_REDUND_CTRL -- requirements
Module: psu_redund_ctrl

Interface
REQ-001 Parameter NUM_PSU, default 2, is the number of PSU slots; legal range 2..8.
REQ-002 Parameter STAGGER_MS, default 10, is the delay in ms between successive PSU enables and the make-before-break overlap time.
REQ-003 Parameter ROTATE_S, default 3600, is the cold-redundancy primary rotation period in s; legal range >= 1.
REQ-004 clk  input  1  main clock, 100MHz.
REQ-005 reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 t1ms  input  1  one-clk pulse every 1ms.
REQ-007 t1s  input  1  one-clk pulse every 1s.
REQ-008 power_supply_on  input  1  sequencer request for PSU output.
REQ-009 cr_enable  input  1  cold-redundancy mode request from Xreg.
REQ-010 ps_prsnt_n  input  NUM_PSU  PSU presence, active-low.
REQ-011 ps_acok  input  NUM_PSU  PSU AC ok.
REQ-012 ps_fail  input  NUM_PSU  PSU fail flags from the PSU block.
REQ-013 brownout_warning  input  1  brownout warning from the PSU block.
REQ-014 ps_enable  output  NUM_PSU  per-PSU enable vector that drives xreg_ps_enable.
REQ-015 active_idx  output  clogb2(NUM_PSU)  current cold-redundancy primary index.
REQ-016 cr_state  output  3  FSM state encoding: OFF=0, STAGGER=1, ALL_ON=2, CR_ACTIVE=3, ROTATE=4, FAILOVER=5.
REQ-017 cr_failover  output  1  one-clk pulse when the FSM enters FAILOVER.

Function
REQ-018 healthy[i] SHALL be ~ps_prsnt_n[i] & ps_acok[i] & ~ps_fail[i]; the number of healthy PSUs is n_healthy.
REQ-019 All outputs SHALL be registered, and all state changes SHALL occur on the clk edge.
REQ-020 When power_supply_on=0, the FSM SHALL go to OFF on the next clk from any state; this condition has the highest priority below reset.
REQ-021 OFF: ps_enable SHALL be all ones and active_idx SHALL hold its value.
REQ-022 OFF exit: when power_supply_on=1, the FSM SHALL go to STAGGER, load ps_enable with a one-hot vector at the lowest present index, and clear the ms counter.
REQ-023 OFF exit with no PSU present: ps_enable SHALL be all zeros and the FSM SHALL go directly to ALL_ON.
REQ-024 STAGGER: on each t1ms, the ms counter SHALL increment.
REQ-025 STAGGER: when the count reaches STAGGER_MS, ps_enable SHALL OR in the next higher present index and the counter SHALL clear.
REQ-026 STAGGER: absent slots SHALL be skipped with no delay consumed.
REQ-027 STAGGER exit: after the highest present index has been enabled, the next clk SHALL go to CR_ACTIVE if cr_enable=1 and n_healthy>=2, otherwise to ALL_ON.
REQ-028 CR_ACTIVE entry: active_idx SHALL load the lowest healthy index, and ps_enable SHALL be one-hot at active_idx from the following cycle.
REQ-029 ALL_ON: ps_enable SHALL equal the present mask (~ps_prsnt_n).
REQ-030 ALL_ON: the FSM SHALL go to CR_ACTIVE when cr_enable=1 and n_healthy>=2.
REQ-031 CR_ACTIVE: a seconds counter SHALL increment on each t1s.
REQ-032 CR_ACTIVE: at count ROTATE_S, the counter SHALL clear and the FSM SHALL go to ROTATE with next_idx = the next healthy index after active_idx, wrapping from NUM_PSU-1 to 0.
REQ-033 CR_ACTIVE: if next_idx==active_idx, the FSM SHALL stay in CR_ACTIVE.
REQ-034 ROTATE: ps_enable SHALL have both active_idx and next_idx bits set.
REQ-035 ROTATE: after STAGGER_MS t1ms pulses, active_idx SHALL load next_idx and the FSM SHALL return to CR_ACTIVE (make-before-break).
REQ-036 In CR_ACTIVE or ROTATE, the FSM SHALL go to FAILOVER if any of the following holds: healthy[active_idx]=0; brownout_warning=1; in ROTATE only, healthy[next_idx]=0.
REQ-037 The failover check (REQ-036) SHALL have priority over the rotation timer.
REQ-038 In CR_ACTIVE or ROTATE, the FSM SHALL go to ALL_ON if cr_enable=0 or n_healthy<2; this check has lower priority than failover (REQ-036).
REQ-039 FAILOVER: ps_enable SHALL equal the present mask, and cr_failover SHALL pulse exactly once on entry.
REQ-040 FAILOVER SHALL be left only via power_supply_on=0, and is not left by cr_enable changes.
REQ-041 Simultaneous t1ms and t1s in the same clk SHALL each be counted once.
REQ-042 Counters SHALL saturate and never wrap.
REQ-043 Counter widths SHALL be clogb2 of the respective parameter plus 1.

Reset
REQ-044 On reset, the FSM SHALL be OFF, ps_enable all ones, active_idx 0, cr_failover 0, and all counters 0.
REQ-045 Reset asserted mid-STAGGER or mid-ROTATE SHALL abort immediately to the REQ-044 values on the next clk.

Verification
REQ-046 NUM_PSU=2, both present and healthy, cr_enable=0, power_supply_on 0->1 -> ps_enable=01, then 11 after 10 t1ms, and state ALL_ON.
REQ-047 cr_enable=1, both healthy, after stagger -> ps_enable=01, active_idx=0; after ROTATE_S t1s -> ps_enable=11 for 10ms, then 10 with active_idx=1.
REQ-048 In CR_ACTIVE with active_idx=0, assert ps_fail[0] -> ps_enable=11 next clk, cr_failover pulses once, state FAILOVER persists while cr_enable toggles.
REQ-049 In CR_ACTIVE, brownout_warning=1 and a t1s rotation-expiry land on the same clk -> FAILOVER is taken and ROTATE is not entered.
REQ-050 Slot 0 absent, NUM_PSU=3 -> stagger enables 010 then 110 with no delay for slot 0; cr_enable=1 -> active_idx=1.
REQ-051 Assert reset for 1 clk mid-ROTATE -> next clk ps_enable=all ones, state OFF, active_idx=0.
